// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
// Mode encodings and the pointer wrap-increment live here.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned ptr_wrap_inc(
        input int unsigned p,
        input int unsigned n
    );
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_decoder.sv
// Combinational binary index to one-hot decoder.
// Indices at or beyond N decode to all-zero.
module onehot_decoder #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] i_idx,
    output logic [N-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < N; i++) begin
            o_onehot[i] = (i_idx == W'(i));
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered fixed / round-robin priority encoder with a
// valid/ready input and a 1-deep output register.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode,
    input  logic [N-1:0] req_in,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx_out,
    output logic [N-1:0] grant_out,
    output logic         none_out,
    output logic         multi_out
);

    logic         r_valid;
    logic [W-1:0] r_idx;
    logic         r_none;
    logic         r_multi;
    logic         r_hit;
    logic [W-1:0] r_ptr;

    logic [N-1:0]   w_hi_mask;
    logic [2*N-1:0] w_dbl;
    logic [W:0]     w_pos;
    logic [W:0]     w_rr_full;
    logic [W-1:0]   w_rr_idx;
    logic [W-1:0]   w_fix_idx;
    logic [W-1:0]   w_idx;
    logic           w_any;
    logic           w_multi;
    logic           w_accept;
    logic [N-1:0]   w_dec;

    assign req_ready = !r_valid || out_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_any     = |req_in;
    assign w_multi   = |(req_in & (req_in - N'(1)));

    // Low half keeps bits at/above ptr, high half is the wrapped copy.
    always_comb begin
        w_hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_hi_mask[i] = (W'(i) >= r_ptr);
        end
    end

    assign w_dbl = {req_in, req_in & w_hi_mask};

    always_comb begin
        w_pos = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (w_dbl[i]) w_pos = (W+1)'(i);
        end
    end

    always_comb begin
        if (w_pos >= (W+1)'(N)) w_rr_full = w_pos - (W+1)'(N);
        else                    w_rr_full = w_pos;
        w_rr_idx = w_rr_full[W-1:0];
    end

    always_comb begin
        w_fix_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (req_in[i]) w_fix_idx = W'(i);
        end
    end

    assign w_idx = (mode == MODE_RR) ? w_rr_idx : w_fix_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_none  <= 1'b0;
            r_multi <= 1'b0;
            r_hit   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_idx   <= w_any ? w_idx : '0;
            r_none  <= !w_any;
            r_multi <= w_multi;
            r_hit   <= w_any;
            if (mode == MODE_RR && w_any) begin
                r_ptr <= W'(ptr_wrap_inc(32'(w_idx), N));
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    onehot_decoder #(
        .N(N),
        .W(W)
    ) u_dec (
        .i_idx   (r_idx),
        .o_onehot(w_dec)
    );

    assign out_valid = r_valid;
    assign idx_out   = r_idx;
    assign none_out  = r_none;
    assign multi_out = r_multi;
    assign grant_out = r_hit ? w_dec : '0;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr at N=16 and N=5.
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mode16 = 1'b0;
    logic [15:0] req16 = '0;
    logic        rv16 = 1'b0;
    logic        rdy16;
    logic        ov16;
    logic        ordy16 = 1'b1;
    logic [3:0]  idx16;
    logic [15:0] gnt16;
    logic        none16;
    logic        multi16;

    logic        mode5 = 1'b0;
    logic [4:0]  req5 = '0;
    logic        rv5 = 1'b0;
    logic        rdy5;
    logic        ov5;
    logic        ordy5 = 1'b1;
    logic [2:0]  idx5;
    logic [4:0]  gnt5;
    logic        none5;
    logic        multi5;

    prio_encoder_rr #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .mode(mode16), .req_in(req16),
        .req_valid(rv16), .req_ready(rdy16), .out_valid(ov16),
        .out_ready(ordy16), .idx_out(idx16), .grant_out(gnt16),
        .none_out(none16), .multi_out(multi16)
    );

    prio_encoder_rr #(.N(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .req_in(req5),
        .req_valid(rv5), .req_ready(rdy5), .out_valid(ov5),
        .out_ready(ordy5), .idx_out(idx5), .grant_out(gnt5),
        .none_out(none5), .multi_out(multi5)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step16(input logic m, input logic [15:0] r,
                          input logic v, input logic o);
        mode16 = m; req16 = r; rv16 = v; ordy16 = o;
        @(posedge clk); #1;
    endtask

    task automatic step5(input logic m, input logic [4:0] r);
        mode5 = m; req5 = r; rv5 = 1'b1; ordy5 = 1'b1;
        @(posedge clk); #1;
        rv5 = 1'b0;
    endtask

    task automatic out16(input string nm, input logic [3:0] i,
                         input logic [15:0] g, input logic n,
                         input logic mu);
        chk({nm, ".valid"}, 32'(ov16), 32'd1);
        chk({nm, ".idx"}, 32'(idx16), 32'(i));
        chk({nm, ".grant"}, 32'(gnt16), 32'(g));
        chk({nm, ".none"}, 32'(none16), 32'(n));
        chk({nm, ".multi"}, 32'(multi16), 32'(mu));
    endtask

    typedef struct {
        logic        m;
        logic [15:0] req;
        logic [3:0]  idx;
        logic [15:0] gnt;
        logic        none;
        logic        multi;
    } vec_t;

    vec_t tv[14];

    initial begin
        tv[0]  = '{1'b0, 16'h0028, 4'd3,  16'h0008, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 16'h8001, 4'd0,  16'h0001, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 16'h8001, 4'd15, 16'h8000, 1'b0, 1'b1};
        tv[3]  = '{1'b1, 16'h8001, 4'd0,  16'h0001, 1'b0, 1'b1};
        tv[4]  = '{1'b1, 16'h0000, 4'd0,  16'h0000, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 16'h0001, 4'd0,  16'h0001, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 16'h0300, 4'd8,  16'h0100, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 16'h0300, 4'd8,  16'h0100, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 16'h0300, 4'd9,  16'h0200, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 16'h0000, 4'd0,  16'h0000, 1'b1, 1'b0};
        tv[10] = '{1'b1, 16'h0301, 4'd0,  16'h0001, 1'b0, 1'b1};
        tv[11] = '{1'b1, 16'h4000, 4'd14, 16'h4000, 1'b0, 1'b0};
        tv[12] = '{1'b1, 16'h8000, 4'd15, 16'h8000, 1'b0, 1'b0};
        tv[13] = '{1'b1, 16'h0002, 4'd1,  16'h0002, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", 32'(ov16), 32'd0);
        chk("rst.idx", 32'(idx16), 32'd0);
        chk("rst.grant", 32'(gnt16), 32'd0);
        chk("rst.none", 32'(none16), 32'd0);
        chk("rst.multi", 32'(multi16), 32'd0);
        chk("rst.ready", 32'(rdy16), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 14; k++) begin
            step16(tv[k].m, tv[k].req, 1'b1, 1'b1);
            out16($sformatf("vec%0d", k), tv[k].idx, tv[k].gnt,
                  tv[k].none, tv[k].multi);
        end

        // drain without a new request keeps the data fields
        step16(1'b1, 16'h0000, 1'b0, 1'b1);
        chk("drain.valid", 32'(ov16), 32'd0);
        chk("drain.idx", 32'(idx16), 32'd1);
        chk("drain.grant", 32'(gnt16), 32'h0002);

        // ptr=2: accept 0x0010 with consumer stalled
        step16(1'b1, 16'h0010, 1'b1, 1'b0);
        out16("bp.acc", 4'd4, 16'h0010, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step16(1'b1, 16'h0020, 1'b1, 1'b0);
            chk($sformatf("bp.ready%0d", k), 32'(rdy16), 32'd0);
            out16($sformatf("bp.hold%0d", k), 4'd4, 16'h0010,
                  1'b0, 1'b0);
        end
        ordy16 = 1'b1;
        #1;
        chk("bp.release_ready", 32'(rdy16), 32'd1);
        @(posedge clk); #1;
        out16("bp.swap", 4'd5, 16'h0020, 1'b0, 1'b0);

        // ptr=6: accept, stall, then reset mid-stall
        step16(1'b1, 16'h0080, 1'b1, 1'b1);
        out16("rs.acc", 4'd7, 16'h0080, 1'b0, 1'b0);
        step16(1'b1, 16'h0001, 1'b1, 1'b0);
        out16("rs.stall", 4'd7, 16'h0080, 1'b0, 1'b0);
        rv16 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rs.valid", 32'(ov16), 32'd0);
        chk("rs.idx", 32'(idx16), 32'd0);
        chk("rs.grant", 32'(gnt16), 32'd0);
        chk("rs.none", 32'(none16), 32'd0);
        chk("rs.multi", 32'(multi16), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step16(1'b1, 16'h0006, 1'b1, 1'b1);
        out16("rs.rr1", 4'd1, 16'h0002, 1'b0, 1'b1);
        step16(1'b1, 16'h0006, 1'b1, 1'b1);
        out16("rs.rr2", 4'd2, 16'h0004, 1'b0, 1'b1);
        step16(1'b0, 16'h0006, 1'b1, 1'b1);
        out16("rs.fix", 4'd1, 16'h0002, 1'b0, 1'b1);
        rv16 = 1'b0;

        // N=5 wrap behaviour, ptr starts at 0
        step5(1'b1, 5'b10000);
        chk("n5.a.idx", 32'(idx5), 32'd4);
        chk("n5.a.grant", 32'(gnt5), 32'h10);
        chk("n5.a.valid", 32'(ov5), 32'd1);
        step5(1'b1, 5'b00001);
        chk("n5.b.idx", 32'(idx5), 32'd0);
        chk("n5.b.grant", 32'(gnt5), 32'h01);
        step5(1'b1, 5'b10001);
        chk("n5.c.idx", 32'(idx5), 32'd4);
        chk("n5.c.multi", 32'(multi5), 32'd1);
        step5(1'b1, 5'b10001);
        chk("n5.d.idx", 32'(idx5), 32'd0);
        step5(1'b0, 5'b11000);
        chk("n5.e.idx", 32'(idx5), 32'd3);
        chk("n5.e.grant", 32'(gnt5), 32'h08);
        step5(1'b1, 5'b00000);
        chk("n5.f.none", 32'(none5), 32'd1);
        chk("n5.f.grant", 32'(gnt5), 32'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the team's fixed 16→4 one-hot encoder / 4→16 decoder pair.
- Accepts an N-bit request vector on a valid/ready handshake and selects one set bit by fixed (lowest-index) or round-robin priority.
- Returns the winner's binary index and its re-decoded one-hot grant, plus none/multi flags, through a 1-deep output register.
- Sits between request sources (interrupt lines, channel requests) and any consumer needing a single index.

Parameters:
- N, 16, request vector width; legal N ≥ 2, any value (not restricted to powers of 2).
- W, $clog2(N), index width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin; sampled only on accept
- req_in  input  N  request vector
- req_valid  input  1  req_in is valid
- req_ready  output  1  block can accept req_in this cycle
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer takes the result this cycle
- idx_out  output  W  winning index
- grant_out  output  N  one-hot of idx_out; all-zero when none_out = 1
- none_out  output  1  accepted req_in was all zeros
- multi_out  output  1  accepted req_in had more than one bit set

Behaviour:
- Reset (async assert, synchronous release on clk):
  - out_valid, idx_out, grant_out, none_out, multi_out = 0.
  - Round-robin pointer ptr = 0.
- Handshake and latency:
  - req_ready = !out_valid || out_ready (combinational; full throughput).
  - Accept when req_valid && req_ready. Result is registered on that edge; out_valid = 1 the following cycle (latency 1).
  - Output hold: while out_valid && !out_ready, all outputs and ptr stay stable and nothing is accepted.
  - Drain: out_ready && out_valid with no new accept clears out_valid next cycle. Other output fields keep their last values.
  - Simultaneous drain + accept: the new result replaces the old one in the same edge; out_valid stays 1.
- Fixed mode:
  - idx = lowest set bit of req_in.
  - ptr unchanged.
- Round-robin mode:
  - idx = first set bit at or above ptr, searching upward and wrapping from N-1 to 0.
  - On accept with non-zero req: ptr ← idx+1, or 0 if idx = N-1.
- Zero request (either mode):
  - none_out = 1, idx_out = 0, grant_out = 0, multi_out = 0.
  - ptr unchanged; out_valid still asserts.
- multi_out = 1 iff popcount(req_in) ≥ 2 at accept.
- Mode change:
  - Takes effect on the next accept only; ptr is retained across mode switches.
  - Fixed-mode accepts do not move ptr.
- ptr only advances on accept, never on drain or stall.
- Reset mid-operation: pending result is discarded immediately; out_valid drops asynchronously.

Decomposition:
- Package prio_enc_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - A function computing the wrap-increment of ptr for a given N.
- Sub-module onehot_decoder (parameters N, W): combinational idx → one-hot. Used to generate grant_out from the registered index, gated by none_out.
- The wrap search is in-line (double-width masked lowest-bit search) inside prio_encoder_rr.

Test Plan:
- Fixed mode, N=16, req_in = 16'h0028, out_ready = 1 → next cycle out_valid = 1, idx_out = 3, grant_out = 16'h0008, multi_out = 1, none_out = 0.
- RR mode, N=16, req_in = 16'h8001 held for 3 accepts from reset → idx_out sequence 0, 15, 0; ptr sequence 1, 0, 1.
- Zero request, req_in = 0 → out_valid = 1, none_out = 1, idx_out = 0, grant_out = 0; ptr unchanged.
- Back-pressure: out_ready = 0 for 4 cycles with req_valid held → req_ready = 0, outputs frozen. Releasing out_ready gives drain + accept in one edge, out_valid continuously 1.
- N=5, RR mode, req_in = 5'b10000 then 5'b00001 → idx_out 4 (ptr wraps to 0), then 0.
- Assert rst_n low while out_valid = 1 and stalled → out_valid, idx_out, grant_out, none_out, multi_out = 0 immediately. First RR accept after release of req_in = 16'h0006 gives idx_out = 1.
